// File: rtl/fork_broadcast_slice.sv
// fork_broadcast_slice: registered one-to-NUM handshake fork; holds a beat until
// every destination selected by its mask has accepted it.
module fork_broadcast_slice #(
    parameter int NUM   = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NUM-1:0]   in_mask,
    output logic [NUM-1:0]   out_valid,
    input  logic [NUM-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [NUM-1:0]   r_done;
    logic             w_complete;
    logic             w_load;

    // every port is either already served or handshaking right now
    assign w_complete = r_valid & (&(r_done | out_ready));
    assign in_ready   = ~r_valid | w_complete;
    assign w_load     = in_valid & in_ready;
    assign out_valid  = {NUM{r_valid}} & ~r_done;
    assign out_data   = r_data;
    assign busy       = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
            r_done  <= ~in_mask;
        end else if (w_complete) begin
            r_valid <= 1'b0;
            r_done  <= '0;
        end else if (r_valid) begin
            r_done  <= r_done | (out_valid & out_ready);
        end
    end
endmodule

// File: tb/tb_fork_broadcast_slice.sv
// tb_fork_broadcast_slice: directed and randomized stimulus; a monitor compares every
// delivery against per-port expected-order queues and a transaction-level model.
module tb_fork_broadcast_slice;
    localparam int NUM   = 2;
    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [NUM-1:0]   in_mask = '0;
    logic [NUM-1:0]   out_valid;
    logic [NUM-1:0]   out_ready = '0;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] q [NUM][$];
    bit               m_held = 0;
    logic [NUM-1:0]   m_owed = '0;
    logic [WIDTH-1:0] m_data = '0;
    int               delivered = 0;

    fork_broadcast_slice #(.NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: a held beat owes delivery to the ports in its mask
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", WIDTH'(out_valid), '0);
            check("rst_busy", WIDTH'(busy), '0);
            check("rst_in_ready", WIDTH'(in_ready), 1);
            check("rst_out_data", out_data, '0);
            m_held = 0;
            m_owed = '0;
            m_data = '0;
            for (int i = 0; i < NUM; i++) q[i].delete();
        end else begin
            logic exp_rdy;
            logic all_served;
            all_served = (m_owed & ~out_ready) == '0;
            exp_rdy = !m_held || all_served;
            check("busy", WIDTH'(busy), WIDTH'(m_held));
            check("out_valid", WIDTH'(out_valid), m_held ? WIDTH'(m_owed) : '0);
            check("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
            check("out_data", out_data, m_data);
            for (int i = 0; i < NUM; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        check("spurious_delivery", WIDTH'(i), WIDTH'(NUM));
                    end else begin
                        check("delivery", out_data, q[i].pop_front());
                        delivered++;
                    end
                end
            end
            if (in_valid && exp_rdy) begin
                m_held = 1;
                m_owed = in_mask;
                m_data = in_data;
                for (int i = 0; i < NUM; i++) if (in_mask[i]) q[i].push_back(in_data);
            end else if (m_held && all_served) begin
                m_held = 0;
                m_owed = '0;
            end else if (m_held) begin
                m_owed = m_owed & ~out_ready;
            end
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [NUM-1:0] m, input logic [NUM-1:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_mask   = m;
        out_ready = r;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // mid-beat reset with port0 already served
        step(1, 64'h77, 2'b11, 2'b00);
        step(0, 0, 0, 2'b01);
        step(0, 0, 0, 2'b00);
        #1 rst_n = 1'b0;
        step(0, 0, 0, 2'b00);
        #1 rst_n = 1'b1;
        // full-rate streaming
        step(1, 64'h1, 2'b11, 2'b11);
        step(1, 64'h2, 2'b11, 2'b11);
        step(1, 64'h3, 2'b11, 2'b11);
        // staggered accept
        step(1, 64'hA5, 2'b11, 2'b11);
        step(0, 0, 0, 2'b01);
        step(0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b10);
        // partial mask, then zero mask
        step(1, 64'h5A, 2'b10, 2'b00);
        step(0, 0, 0, 2'b01);
        step(0, 0, 0, 2'b10);
        step(1, 64'hBEEF, 2'b00, 2'b00);
        step(0, 0, 0, 2'b00);
        // back-pressure hold with a competing input beat
        step(1, 64'hC0DE, 2'b11, 2'b00);
        repeat (10) step(1, 64'hDEAD, 2'b11, 2'b00);
        step(0, 0, 0, 2'b11);
        // randomized traffic with varying downstream readiness
        for (int n = 0; n < 3000; n++) begin
            int p;
            logic [NUM-1:0] r;
            p = (n / 500) % 3;
            for (int i = 0; i < NUM; i++) r[i] = ($urandom_range(0, 3) < (p + 1));
            step(logic'($urandom_range(0, 1)), {$urandom, $urandom}, NUM'($urandom), r);
        end
        // drain
        repeat (6) step(0, 0, 0, '1);
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM; i++) check("queue_drained", WIDTH'(q[i].size()), '0);
        check("delivered_any", WIDTH'(delivered > 100), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
